// File: rtl/key_led.sv
// key_led: push-button front end -- synchronise, debounce press/release, toggle LED per press
//   sclk     in  system clock, all logic on posedge
//   s_rst_n  in  asynchronous active-low reset
//   key      in  raw active-low button, asynchronous to sclk, may bounce
//   led      out registered LED drive, toggles once per accepted press
module key_led #(
    parameter int DELAY_10MS = 500_000
) (
    input  logic sclk,
    input  logic s_rst_n,
    input  logic key,
    output logic led
);
    localparam int CNT_W = $clog2(DELAY_10MS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DELAY_10MS - 1);

    typedef enum logic [1:0] {IDLE, FILT_DN, DOWN, FILT_UP} state_t;

    logic [1:0]       sync_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             led_q, led_d;
    logic             key_s;

    assign key_s = sync_q[1];
    assign led   = led_q;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
        end
    end

    // The counter is cleared on every transition and in the stable states,
    // so it only ever advances while a candidate level holds.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        led_d   = led_q;
        case (state_q)
            IDLE:    if (!key_s) state_d = FILT_DN;
            FILT_DN: begin
                if (key_s) state_d = IDLE;
                else if (cnt_q == LAST) begin
                    state_d = DOWN;
                    led_d   = ~led_q;
                end else cnt_d = cnt_q + CNT_W'(1);
            end
            DOWN:    if (key_s) state_d = FILT_UP;
            FILT_UP: begin
                if (!key_s) state_d = DOWN;
                else if (cnt_q == LAST) state_d = IDLE;
                else cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_key_led.sv
// tb_key_led: directed bench for key_led with a run-length debounce model
module tb_key_led;
    localparam int D = 110;

    logic sclk = 1'b0;
    logic s_rst_n = 1'b0;
    logic key = 1'b1;
    logic led;
    int n_chk = 0;
    int n_fail = 0;

    always #5 sclk = ~sclk;

    key_led #(.DELAY_10MS(D)) dut (
        .sclk(sclk),
        .s_rst_n(s_rst_n),
        .key(key),
        .led(led)
    );

    // Model: key_s is key seen two edges late; the accepted level flips once
    // key_s has differed from it on D+1 consecutive samples; a flip to
    // "pressed" toggles the LED.
    logic [1:0] m_sh;
    logic       m_acc;
    int         m_run;
    logic       m_led;

    always @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            m_sh  <= 2'b11;
            m_acc <= 1'b1;
            m_run <= 0;
            m_led <= 1'b0;
        end else begin
            m_sh <= {m_sh[0], key};
            if (m_sh[1] == m_acc) m_run <= 0;
            else if (m_run + 1 == D + 1) begin
                m_acc <= ~m_acc;
                m_run <= 0;
                if (m_acc) m_led <= ~m_led;
            end else m_run <= m_run + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge sclk) check("led_vs_model", {31'd0, led}, {31'd0, m_led});

    task automatic cycles(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic hold(input logic v, input int n);
        key = v;
        cycles(n);
    endtask

    // Called at a negedge; the next posedge is the first capture of key=0.
    task automatic latency(input logic pre);
        key = 1'b0;
        repeat (D + 2) @(posedge sclk);
        @(negedge sclk);
        check("led_before_edge_113", {31'd0, led}, {31'd0, pre});
        @(posedge sclk);
        @(negedge sclk);
        check("led_at_edge_113", {31'd0, led}, {31'd0, ~pre});
    endtask

    initial begin
        repeat (9) begin
            @(negedge sclk);
            key = ~key;
        end
        check("reset_led", {31'd0, led}, 32'd0);
        check("reset_cnt", 32'(dut.cnt_q), 32'd0);
        check("reset_state", 32'(dut.state_q), 32'd0);
        @(negedge sclk);
        key = 1'b1;
        s_rst_n = 1'b1;
        cycles(20);

        latency(1'b0);
        cycles(300 - (D + 3));
        hold(1'b1, 300);
        check("clean_press_after_release", {31'd0, led}, 32'd1);

        hold(1'b1, 50);
        repeat (100) begin
            key = 1'($urandom_range(0, 1));
            cycles(1);
        end
        hold(1'b0, 300);
        check("bounced_press_toggled", {31'd0, led}, 32'd0);
        repeat (100) begin
            key = 1'($urandom_range(0, 1));
            cycles(1);
        end
        hold(1'b1, 300);
        check("bounced_release_no_toggle", {31'd0, led}, 32'd0);

        hold(1'b0, 100);
        hold(1'b1, 20);
        check("glitch_led", {31'd0, led}, 32'd0);
        check("glitch_state_idle", 32'(dut.state_q), 32'd0);

        hold(1'b0, 300);
        check("cycle1_press", {31'd0, led}, 32'd1);
        hold(1'b1, 400);
        hold(1'b0, 300);
        check("cycle2_press", {31'd0, led}, 32'd0);
        hold(1'b1, 400);
        check("cycle2_release", {31'd0, led}, 32'd0);

        hold(1'b0, 300);
        hold(1'b1, 300);
        check("pre_reset_press", {31'd0, led}, 32'd1);

        hold(1'b0, 52);
        check("filt_dn_cnt", 32'(dut.cnt_q), 32'd49);
        s_rst_n = 1'b0;
        #1;
        check("midfilter_reset_led", {31'd0, led}, 32'd0);
        check("midfilter_reset_cnt", 32'(dut.cnt_q), 32'd0);
        check("midfilter_reset_state", 32'(dut.state_q), 32'd0);
        cycles(3);
        s_rst_n = 1'b1;
        latency(1'b0);
        cycles(300 - (D + 3));
        hold(1'b1, 300);
        check("post_reset_press", {31'd0, led}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
